bloke2b_digest_capture: RTL
===========================

// Module: bloke2b_digest_capture
// PURPOSE
//   Sits directly downstream of the bloke2b hasher. Collects its byte-serial digest
//   (dout/dout_valid/dout_end) into a parallel DIGEST_BYTES-wide register.
//   Checks the byte count, compares the digest against an expected value, and offers
//   the result to the consumer over a valid/ready handshake. The hasher has no output
//   backpressure, so this block owns overrun detection.
// PARAMETERS
//   DIGEST_BYTES  64  bytes per digest; width W = 8*DIGEST_BYTES
//   CNT_W         8   byte-counter width; saturates at 2^CNT_W-1
// PORTS
//   clk          in   1      clock; all logic on posedge
//   rst          in   1      synchronous, active-high reset
//   start        in   1      same strobe the hasher sees; begins a new capture
//   din          in   8      digest byte from hasher dout
//   din_valid    in   1      hasher dout_valid
//   din_end      in   1      hasher dout_end; marks the final cycle of a digest
//   expected     in   W      reference digest, first-received byte in [W-1 -: 8]
//   digest       out  W      captured digest, first byte in MSBs
//   byte_count   out  CNT_W  bytes received in this capture (saturating)
//   res_valid    out  1      result available
//   res_ready    in   1      consumer accepts the result
//   match        out  1      digest==expected && byte_count==DIGEST_BYTES
//   len_err      out  1      byte_count != DIGEST_BYTES at din_end
//   overrun      out  1      sticky: input arrived while a result was unconsumed
// BEHAVIOUR
//   Reset: state=IDLE; digest=0, byte_count=0, res_valid=0, match=0, len_err=0, overrun=0.
//   FSM states: IDLE, COLLECT, HOLD.
//   IDLE -> COLLECT on start: clear digest, byte_count, match and len_err.
//     overrun is NOT cleared.
//   COLLECT, on each din_valid cycle:
//     digest <= {digest[W-9:0], din}
//     byte_count <= byte_count+1, saturating
//     Excess bytes keep only the last DIGEST_BYTES. Short digests are zero-filled in
//     the MSBs.
//   COLLECT, on din_end: a byte with din_valid in the same cycle is included.
//     Next cycle: state=HOLD, res_valid=1. match and len_err are computed from the
//     final values (including that byte) and are registered with res_valid.
//     Latency: 1 clk from the din_end edge to res_valid.
//   HOLD: digest, byte_count, match and len_err are stable while res_valid=1.
//     res_valid && res_ready -> IDLE; res_valid=0 on the next cycle.
//   start while in COLLECT: restart the capture (clear, stay in COLLECT). No result
//     is issued for the abandoned digest.
//   start while in HOLD and no handshake that cycle: set overrun=1; the result is
//     kept and the new digest is dropped.
//   start and handshake in the same cycle (HOLD): the handshake completes and the
//     block goes to COLLECT with a cleared capture. No overrun.
//   din_valid or din_end outside COLLECT: ignored. In HOLD, din_valid also sets
//     overrun=1.
//   din_end with no byte received: len_err=1, match=0, digest=0.
//   overrun clears only on rst.
//   rst mid-operation: return to the reset values within 1 clk; any partial digest
//     is discarded.
//   match uses a full W-bit equality, sampled when entering HOLD. Changing expected
//     afterwards does not alter match.
// TESTING
//   1. Reset, then start, then bytes 0x00..0x3F, din_end with the last byte, expected
//      = same pattern.
//      -> res_valid 1 clk later; digest[511:504]=00, [7:0]=3F; byte_count=64;
//         match=1, len_err=0.
//   2. As 1, but expected differs in byte 0x20 only -> match=0, len_err=0,
//      digest unchanged.
//   3. start, then 3 bytes A1 B2 C3, then din_end alone on a following cycle.
//      -> digest=...00A1B2C3 (upper 61 bytes zero); byte_count=3; len_err=1, match=0.
//   4. 66 bytes 0x00..0x41, then din_end -> digest holds 0x02..0x41; byte_count=66;
//      len_err=1.
//   5. Hold res_ready=0 for 5 clks and send start plus bytes from a second digest.
//      -> first result and outputs stable throughout; overrun=1.
//      Then res_ready=1 -> res_valid=0 next clk; overrun stays 1 until rst.
//   6. Pulse rst after 10 bytes of a capture -> all outputs at reset values next clk.
//      A following full 64-byte capture gives a correct digest with match=1.

Source files
------------

// File: rtl/bloke2b_digest_capture.sv
// rtl/bloke2b_digest_capture.sv - byte-serial digest capture, length/compare check and result handshake
//
// Purpose:
//   Collects the byte-serial digest stream from the bloke2b hasher into a
//   DIGEST_BYTES-wide register, checks the received byte count, compares the
//   captured digest against a reference, and holds the result for a
//   valid/ready consumer. The hasher cannot be stalled, so any input that
//   shows up while a result is still waiting raises a sticky overrun flag.
//
// Ports:
//   clk         clock, all logic on posedge
//   rst         synchronous active-high reset
//   start       begins a new capture (same strobe the hasher sees)
//   din         digest byte from the hasher
//   din_valid   din carries a byte this cycle
//   din_end     final cycle of a digest (a byte valid in this cycle counts)
//   expected    reference digest, first-received byte in the MSBs
//   digest      captured digest, first-received byte in the MSBs
//   byte_count  bytes received in the current capture, saturating
//   res_valid   result available
//   res_ready   consumer accepts the result
//   match       digest equals expected and the length was exact
//   len_err     byte count differed from DIGEST_BYTES at din_end
//   overrun     sticky, input arrived while a result was unconsumed

module bloke2b_digest_capture #(
    parameter int DIGEST_BYTES = 64,
    parameter int CNT_W        = 8,
    localparam int W           = 8 * DIGEST_BYTES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       din,
    input  logic             din_valid,
    input  logic             din_end,
    input  logic [W-1:0]     expected,
    output logic [W-1:0]     digest,
    output logic [CNT_W-1:0] byte_count,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             match,
    output logic             len_err,
    output logic             overrun
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] COUNT_MAX  = '1;
    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(DIGEST_BYTES);

    state_t state;
    state_t state_next;

    // Control strobes decoded by the FSM and consumed by the datapath.
    logic cap_clear;   // wipe the capture registers for a fresh digest
    logic cap_shift;   // accept din into the shift register
    logic cap_done;    // din_end seen: latch match/len_err and raise res_valid
    logic res_take;    // handshake completes this cycle
    logic ovr_set;     // input arrived while the result was unconsumed

    // Final values including a byte that arrives together with din_end, so
    // match and len_err can be registered in the same edge as res_valid.
    logic [W-1:0]     digest_fin;
    logic [CNT_W-1:0] count_fin;
    logic             len_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cap_clear  = 1'b0;
        cap_shift  = 1'b0;
        cap_done   = 1'b0;
        res_take   = 1'b0;
        ovr_set    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    cap_clear  = 1'b1;
                    state_next = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (start) begin
                    // Abandon the partial digest; no result is issued for it.
                    cap_clear = 1'b1;
                end else begin
                    cap_shift = din_valid;
                    if (din_end) begin
                        cap_done   = 1'b1;
                        state_next = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (res_ready) begin
                    res_take = 1'b1;
                    if (start) begin
                        // Result leaves this cycle, so the new digest can be
                        // captured without losing anything.
                        cap_clear  = 1'b1;
                        state_next = S_COLLECT;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else if (start) begin
                    ovr_set = 1'b1;
                end
                // A byte in HOLD is always dropped, whether or not the
                // result is taken in the same cycle.
                if (din_valid) begin
                    ovr_set = 1'b1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        digest_fin = digest;
        count_fin  = byte_count;
        if (cap_shift) begin
            digest_fin = {digest[W-9:0], din};
            if (byte_count != COUNT_MAX) begin
                count_fin = byte_count + CNT_W'(1);
            end
        end
        len_ok = (count_fin == COUNT_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digest     <= '0;
            byte_count <= '0;
            res_valid  <= 1'b0;
            match      <= 1'b0;
            len_err    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (cap_clear) begin
                digest     <= '0;
                byte_count <= '0;
                match      <= 1'b0;
                len_err    <= 1'b0;
            end else if (cap_shift) begin
                digest     <= digest_fin;
                byte_count <= count_fin;
            end

            if (cap_done) begin
                match     <= (digest_fin == expected) && len_ok;
                len_err   <= !len_ok;
                res_valid <= 1'b1;
            end else if (res_take) begin
                res_valid <= 1'b0;
            end

            if (ovr_set) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
